// File: rtl/reg_file_bypass.sv
// -----------------------------------------------------------------------------
// reg_file_bypass
//   Architectural register file for the 16-bit WISC datapath.
//   16 general registers, two asynchronous read ports and one synchronous
//   write port. A write presented in WB is forwarded to the read ports in the
//   same cycle, so ID sees it without waiting for the clock edge.
//   R0 is hard-wired to zero and is not backed by flops.
//
// Ports
//   clk       in   1       clock, state updates on rising edge
//   rst       in   1       asynchronous active-high reset (clears registers)
//   SrcReg1   in   ADDR_W  read port 1 register index
//   SrcReg2   in   ADDR_W  read port 2 register index
//   DstReg    in   ADDR_W  write port register index
//   WriteReg  in   1       write enable for DstReg/DstData
//   DstData   in   DATA_W  write data (stored verbatim)
//   SrcData1  out  DATA_W  read port 1 data (combinational)
//   SrcData2  out  DATA_W  read port 2 data (combinational)
// -----------------------------------------------------------------------------
module reg_file_bypass #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  input  logic [ADDR_W-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Register storage; index 0 has no flops because R0 always reads zero.
  logic [DATA_W-1:0]   mem_r [1:NUM_REGS-1];

  logic [NUM_REGS-1:0] wr_dec_s;
  logic [NUM_REGS-1:0] rd1_dec_s;
  logic [NUM_REGS-1:0] rd2_dec_s;
  logic [DATA_W-1:0]   rd1_mem_s;
  logic [DATA_W-1:0]   rd2_mem_s;
  logic                hit1_s;
  logic                hit2_s;

  // One-hot write decoder gated by WriteReg; bit 0 is never set so R0 writes vanish.
  always_comb begin
    wr_dec_s = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      if (WriteReg && (DstReg == ADDR_W'(i))) begin
        wr_dec_s[i] = 1'b1;
      end else begin
        wr_dec_s[i] = 1'b0;
      end
    end
  end

  // One-hot read decoders, one per port.
  always_comb begin
    rd1_dec_s = {NUM_REGS{1'b0}};
    rd2_dec_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd1_dec_s[i] = (SrcReg1 == ADDR_W'(i));
      rd2_dec_s[i] = (SrcReg2 == ADDR_W'(i));
    end
  end

  // Per-register flops: async clear, load on a decoded write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_dec_s[i]) begin
          mem_r[i] <= DstData;
        end
      end
    end
  end

  // AND-OR read muxes driven by the one-hot decoders; bit 0 contributes nothing.
  always_comb begin
    rd1_mem_s = {DATA_W{1'b0}};
    rd2_mem_s = {DATA_W{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      rd1_mem_s = rd1_mem_s | (mem_r[i] & {DATA_W{rd1_dec_s[i]}});
      rd2_mem_s = rd2_mem_s | (mem_r[i] & {DATA_W{rd2_dec_s[i]}});
    end
  end

  // Bypass hit: the write decoder already excludes R0 and disabled writes.
  always_comb begin
    hit1_s = |(rd1_dec_s & wr_dec_s);
    hit2_s = |(rd2_dec_s & wr_dec_s);
  end

  // Port 1 output select: reset, R0, bypass, then stored value.
  always_comb begin
    if (rst) begin
      SrcData1 = {DATA_W{1'b0}};
    end else if (rd1_dec_s[0]) begin
      SrcData1 = {DATA_W{1'b0}};
    end else if (hit1_s) begin
      SrcData1 = DstData;
    end else begin
      SrcData1 = rd1_mem_s;
    end
  end

  // Port 2 output select: reset, R0, bypass, then stored value.
  always_comb begin
    if (rst) begin
      SrcData2 = {DATA_W{1'b0}};
    end else if (rd2_dec_s[0]) begin
      SrcData2 = {DATA_W{1'b0}};
    end else if (hit2_s) begin
      SrcData2 = DstData;
    end else begin
      SrcData2 = rd2_mem_s;
    end
  end

endmodule

// File: tb/tb_reg_file_bypass.sv
// -----------------------------------------------------------------------------
// tb_reg_file_bypass
//   Directed and randomised checks of reg_file_bypass. Inputs change just after
//   the falling edge; combinational reads are sampled 1 ns later, well away
//   from the rising edge where writes commit.
// -----------------------------------------------------------------------------
module tb_reg_file_bypass;

  logic        clk;
  logic        rst;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;

  int checks;
  int failures;

  logic [15:0] model_mem [16];

  reg_file_bypass #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference read: R0 -> 0, active write to same register -> DstData, else stored.
  function automatic logic [15:0] exp_read(input logic [3:0] r);
    if (r == 4'd0) return 16'h0000;
    if (WriteReg && (DstReg == r)) return DstData;
    return model_mem[r];
  endfunction

  // Downstream shifter stand-in: mode 0 arithmetic right, mode 1 left.
  function automatic logic [15:0] shift_fn(input logic [15:0] v, input int amt, input logic mode);
    if (mode) return v << amt;
    return 16'($signed(v) >>> amt);
  endfunction

  // Advance one clock: rising edge commits the write in the model, then back to negedge.
  task automatic step();
    @(posedge clk);
    if (!rst && WriteReg && (DstReg != 4'd0)) model_mem[DstReg] = DstData;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [3:0] r, input logic [15:0] d);
    WriteReg = 1'b1;
    DstReg   = r;
    DstData  = d;
    step();
    WriteReg = 1'b0;
  endtask

  task automatic read_pair(input string tag, input logic [3:0] r1, input logic [3:0] r2,
                           input logic [15:0] e1, input logic [15:0] e2);
    SrcReg1 = r1;
    SrcReg2 = r2;
    #1;
    check_eq({tag, "_p1"}, SrcData1, e1);
    check_eq({tag, "_p2"}, SrcData2, e2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
    rst      = 1'b1;
    SrcReg1  = 4'd5;
    SrcReg2  = 4'd9;
    DstReg   = 4'd0;
    WriteReg = 1'b0;
    DstData  = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    read_pair("reset_state", 4'd5, 4'd9, 16'h0000, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Mid-run reset clears written data immediately; writes and bypass are suppressed.
    do_write(4'd5, 16'h1234);
    read_pair("pre_reset", 4'd5, 4'd0, 16'h1234, 16'h0000);
    rst      = 1'b1;
    WriteReg = 1'b1;
    DstReg   = 4'd5;
    DstData  = 16'hBEEF;
    read_pair("in_reset", 4'd5, 4'd6, 16'h0000, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
    rst      = 1'b0;
    WriteReg = 1'b0;
    read_pair("post_reset", 4'd5, 4'd6, 16'h0000, 16'h0000);

    // Write all registers, then read back every pair.
    for (int k = 1; k < 16; k++) do_write(4'(k), 16'hA500 | 16'(k));
    for (int k = 0; k < 16; k++) begin
      logic [15:0] e1;
      logic [15:0] e2;
      e1 = (k == 0) ? 16'h0000 : (16'hA500 | 16'(k));
      e2 = (k == 15) ? 16'h0000 : (16'hA500 | 16'(15 - k));
      read_pair("write_all", 4'(k), 4'(15 - k), e1, e2);
    end

    // R0 guard: neither bypass nor storage for R0.
    WriteReg = 1'b1;
    DstReg   = 4'd0;
    DstData  = 16'hFFFF;
    read_pair("r0_same_cycle", 4'd0, 4'd0, 16'h0000, 16'h0000);
    step();
    WriteReg = 1'b0;
    read_pair("r0_after_edge", 4'd0, 4'd1, 16'h0000, 16'hA501);

    // Bypass: R3 holds 1, new value visible before the edge on both ports.
    do_write(4'd3, 16'h0001);
    read_pair("r3_old", 4'd3, 4'd4, 16'h0001, 16'hA504);
    WriteReg = 1'b1;
    DstReg   = 4'd3;
    DstData  = 16'h8000;
    read_pair("bypass", 4'd3, 4'd4, 16'h8000, 16'hA504);
    read_pair("bypass_both", 4'd3, 4'd3, 16'h8000, 16'h8000);
    step();
    WriteReg = 1'b0;
    read_pair("bypass_after", 4'd3, 4'd4, 16'h8000, 16'hA504);

    // Disabled write: no bypass, no update.
    WriteReg = 1'b0;
    DstReg   = 4'd7;
    DstData  = 16'hDEAD;
    read_pair("wr_off_same", 4'd7, 4'd7, 16'hA507, 16'hA507);
    step();
    read_pair("wr_off_after", 4'd7, 4'd8, 16'hA507, 16'hA508);

    // Shifter feed from port 1.
    do_write(4'd2, 16'h8001);
    read_pair("r2", 4'd2, 4'd0, 16'h8001, 16'h0000);
    check_eq("shift_asr4", shift_fn(SrcData1, 4, 1'b0), 16'hF800);
    check_eq("shift_sll4", shift_fn(SrcData1, 4, 1'b1), 16'h0010);

    // Randomised write/read sweep against the reference model.
    for (int n = 0; n < 10000; n++) begin
      SrcReg1  = 4'($urandom_range(0, 15));
      SrcReg2  = ($urandom_range(0, 3) == 0) ? SrcReg1 : 4'($urandom_range(0, 15));
      DstReg   = ($urandom_range(0, 2) == 0) ? SrcReg1 : 4'($urandom_range(0, 15));
      WriteReg = 1'($urandom_range(0, 1));
      DstData  = 16'($urandom);
      #1;
      check_eq("rand_p1", SrcData1, exp_read(SrcReg1));
      check_eq("rand_p2", SrcData2, exp_read(SrcReg2));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
